// File: rtl/seq_alu.sv
// seq_alu: registered, parametrised ALU with a start/busy/done handshake.
// Single-cycle ops (ADD, SUB, AND, OR, XOR, SHL) write their result at the
// accepting edge. MUL (shift-add) and DIV (restoring) each run WIDTH
// iterations in CALC before their result is written.
//
// Ports:
//   clk_i    rising-edge clock
//   rst_i    asynchronous active-high reset
//   start_i  operation request, sampled only in IDLE
//   A_i/B_i  unsigned operands, WIDTH bits
//   opSel    3-bit opcode, sampled with start_i
//   o_alu    2*WIDTH result register, held until the next completion
//   busy_o   high while iterating (CALC)
//   done_o   one-cycle pulse, result valid
//   div0_o   DIV with B=0 produced the current result
module seq_alu #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [WIDTH-1:0]     A_i,
  input  logic [WIDTH-1:0]     B_i,
  input  logic [2:0]           opSel,
  output logic [2*WIDTH-1:0]   o_alu,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 div0_o
);

  localparam int unsigned RW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_MUL = 3'b110,
    OP_DIV = 3'b111
  } op_t;

  state_t state_q, state_d;
  op_t    op_q;

  logic [CW-1:0]    cnt_q;
  logic [RW-1:0]    mcand_q;   // multiplicand, shifted left each iteration
  logic [WIDTH-1:0] mplr_q;    // multiplier, shifted right each iteration
  logic [RW-1:0]    prod_q;
  logic [WIDTH-1:0] divisor_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;     // holds dividend bits, replaced by quotient bits

  logic             is_iter;
  logic             last_iter;
  logic [RW-1:0]    quick;
  logic [RW-1:0]    a_ext;
  logic [RW-1:0]    b_ext;
  logic [RW-1:0]    prod_nxt;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             ge;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;

  assign is_iter   = (opSel == OP_MUL) || (opSel == OP_DIV);
  assign last_iter = (cnt_q == CW'(1));
  assign busy_o    = (state_q == CALC);
  assign done_o    = (state_q == DONE);

  // Single-cycle result; shifting by >= RW naturally yields zero.
  always_comb begin
    a_ext = RW'(A_i);
    b_ext = RW'(B_i);
    quick = '0;
    case (opSel)
      OP_ADD:  quick = a_ext + b_ext;
      OP_SUB:  quick = a_ext - b_ext;
      OP_AND:  quick = a_ext & b_ext;
      OP_OR:   quick = a_ext | b_ext;
      OP_XOR:  quick = a_ext ^ b_ext;
      OP_SHL:  quick = a_ext << B_i;
      default: quick = '0;
    endcase
  end

  // One shift-add step and one restoring-division step per CALC cycle.
  // With a zero divisor every trial succeeds, so the quotient fills with
  // ones and the remainder collects the dividend unchanged.
  always_comb begin
    prod_nxt = mplr_q[0] ? (prod_q + mcand_q) : prod_q;
    trial    = {rem_q, quo_q[WIDTH-1]};
    ge       = (trial >= {1'b0, divisor_q});
    diff     = trial - {1'b0, divisor_q};
    rem_nxt  = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_nxt  = {quo_q[WIDTH-2:0], ge};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = is_iter ? CALC : DONE;
      CALC:    if (last_iter) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_q      <= OP_ADD;
      cnt_q     <= '0;
      mcand_q   <= '0;
      mplr_q    <= '0;
      prod_q    <= '0;
      divisor_q <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      o_alu     <= '0;
      div0_o    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            op_q      <= op_t'(opSel);
            cnt_q     <= CW'(WIDTH);
            mcand_q   <= RW'(A_i);
            mplr_q    <= B_i;
            prod_q    <= '0;
            divisor_q <= B_i;
            rem_q     <= '0;
            quo_q     <= A_i;
            if (!is_iter) begin
              o_alu  <= quick;
              div0_o <= 1'b0;
            end
          end
        end
        CALC: begin
          cnt_q   <= cnt_q - 1'b1;
          mcand_q <= mcand_q << 1;
          mplr_q  <= mplr_q >> 1;
          prod_q  <= prod_nxt;
          rem_q   <= rem_nxt;
          quo_q   <= quo_nxt;
          if (last_iter) begin
            if (op_q == OP_MUL) begin
              o_alu  <= prod_nxt;
              div0_o <= 1'b0;
            end else begin
              o_alu  <= {rem_nxt, quo_nxt};
              div0_o <= (divisor_q == '0);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered successor to the 4-bit combinational ALU (A_i, B_i, 3-bit opSel, double-width o_alu).
- Generalises operand width and keeps the 3-bit opcode map.
- Adds a start/busy/done handshake. Single-cycle logic ops coexist with iterative multi-cycle MUL (shift-add) and DIV (restoring).
- Sits between an operand source (register file or bench driver) and a result sink that waits on done_o.

Parameters:
- WIDTH, 4, operand width in bits; legal range 2..16; result width is 2*WIDTH.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- start_i  input  1  request; sampled only in IDLE.
- A_i  input  WIDTH  operand A, unsigned.
- B_i  input  WIDTH  operand B, unsigned.
- opSel  input  3  operation select; sampled with start_i.
- o_alu  output  2*WIDTH  result register.
- busy_o  output  1  high while in CALC.
- done_o  output  1  one-cycle pulse: result valid.
- div0_o  output  1  DIV attempted with B=0; valid with done_o.

Behaviour:
- Reset (async, any state, including mid-CALC):
  - state=IDLE; o_alu=0, busy_o=0, done_o=0, div0_o=0.
  - Iteration counter and operand latches cleared. The in-flight op is discarded and does not resume.
- States: IDLE, CALC, DONE.
- IDLE:
  - start_i=1 latches A_i, B_i, opSel.
  - opSel 110 or 111: go to CALC, counter=WIDTH.
  - Any other opSel: result computed and written to o_alu at the same edge; go to DONE.
  - start_i=0: stay in IDLE.
- CALC:
  - busy_o=1; one iteration per cycle; counter decrements.
  - After the WIDTH-th iteration, write the final result to o_alu and go to DONE.
- DONE: done_o=1 for exactly one cycle, then IDLE unconditionally.
- Latency, counted in edges from the accepting edge to done_o high:
  - Single-cycle ops: 1 (done_o high in the cycle after start is sampled).
  - MUL/DIV: WIDTH+1.
  - Back-to-back starts: start_i held high is accepted again on the first IDLE cycle after DONE.
- start_i in CALC or DONE is ignored (no queuing). Changing A_i/B_i/opSel during CALC has no effect.
- o_alu holds its last result until the next completion. It is not cleared at start and not modified during CALC.
- div0_o is updated only when a result is written: set for DIV with B=0, otherwise cleared.
- Opcode map (zero-extend A and B to 2*WIDTH first; all results mod 2^(2*WIDTH)):
  - 000 ADD: A+B; the carry lands in bit WIDTH.
  - 001 SUB: A-B, two's complement across the full 2*WIDTH (3-5 -> all ones except bit0=0).
  - 010 AND, 011 OR, 100 XOR: bitwise; upper WIDTH bits are 0.
  - 101 SHL: A << B; shift amount >= 2*WIDTH gives 0.
  - 110 MUL: unsigned A*B, exact; one shift-add iteration per CALC cycle.
  - 111 DIV: o_alu = {remainder, quotient}, each WIDTH bits. Restoring division, one quotient bit per CALC cycle.
  - DIV with B=0: still takes WIDTH cycles; quotient = all ones, remainder = A, div0_o=1.

Test Plan:
- Reset/exhaustive (WIDTH=4):
  - Assert rst_i asynchronously between edges -> all outputs 0 immediately.
  - Then sweep all {opSel,B_i,A_i} combinations (2048), each start/wait-for-done against a reference model -> zero mismatches.
  - done_o high exactly one cycle per op.
- Single-cycle latency: ADD A=4'hF,B=4'h1 -> done_o one edge after start, o_alu=8'h10. SUB A=3,B=5 -> 8'hFE.
- MUL: A=15,B=15 -> busy_o high 4 cycles, done_o at edge 5, o_alu=8'hE1. start_i pulsed during busy -> ignored, result unchanged.
- DIV: A=13,B=4 -> o_alu=8'h13, div0_o=0. A=9,B=0 -> o_alu=8'h9F, div0_o=1. Next ADD clears div0_o.
- Reset mid-MUL: rst_i at CALC cycle 2 -> IDLE, o_alu=0, no done_o. Fresh MUL 3*5 -> 8'h0F.
- Parameter: WIDTH=8, MUL 255*255 -> 16'hFE01 after 9 edges. DIV 200/7 -> {8'd4,8'd28}.
